// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int beats(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    function automatic int cnt_w(input int nbeats);
        return (nbeats <= 1) ? 1 : $clog2(nbeats);
    endfunction

endpackage

// File: rtl/piso_shift_datapath.sv
// Shift register, load mux, lane select and beat counter for the serializer.
module piso_shift_datapath
    import serializer_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int LANE_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data_in,
    output logic [LANE_W-1:0] lane,
    output logic              last
);
    localparam int BEATS = beats(DATA_W, LANE_W);
    localparam int CNT_W = cnt_w(BEATS);

    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] shifted;
    logic [CNT_W-1:0]  cnt;

    // Single-beat words never shift, so the zero-width slice is avoided.
    generate
        if (BEATS == 1) begin : g_one
            assign shifted = '0;
            assign lane    = sr;
        end else if (MSB_FIRST) begin : g_msb
            assign shifted = {sr[DATA_W-LANE_W-1:0], {LANE_W{1'b0}}};
            assign lane    = sr[DATA_W-1 -: LANE_W];
        end else begin : g_lsb
            assign shifted = {{LANE_W{1'b0}}, sr[DATA_W-1:LANE_W]};
            assign lane    = sr[LANE_W-1:0];
        end
    endgenerate

    assign last = (cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= data_in;
            cnt <= '0;
        end else if (shift) begin
            sr  <= shifted;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/piso_serializer_64.sv
// 64-bit parallel-in/serial-out stage with valid/ready on both sides and zero-bubble reload.
module piso_serializer_64
    import serializer_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int LANE_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANE_W-1:0] ser_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);
    state_t            state, state_nxt;
    logic              load, shift, last, xfer;
    logic [LANE_W-1:0] lane;

    // Accept a new word when empty, or on the edge the final beat leaves.
    assign in_ready = rst & ((state == IDLE) | ((state == SHIFT) & last & out_ready));
    assign load     = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;
    assign shift    = xfer & ~last;

    piso_shift_datapath #(
        .DATA_W    (DATA_W),
        .LANE_W    (LANE_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_dp (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .data_in (data_in),
        .lane    (lane),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (load) state_nxt = SHIFT;
            SHIFT: if (xfer && last && !load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == SHIFT);
        busy      = (state == SHIFT);
        out_last  = (state == SHIFT) & last;
        ser_out   = (state == SHIFT) ? lane : '0;
    end

endmodule

// File: tb/tb_piso_serializer_64.sv
// Directed bench: MSB-first, LSB-first and full-width-lane serializers on shared stimulus.
module tb_piso_serializer_64;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data_in;
    logic        in_valid;
    logic        out_ready;

    logic        m_in_ready, m_out_valid, m_out_last, m_busy;
    logic [7:0]  m_ser_out;
    logic        l_in_ready, l_out_valid, l_out_last, l_busy;
    logic [7:0]  l_ser_out;
    logic        w_in_ready, w_out_valid, w_out_last, w_busy;
    logic [63:0] w_ser_out;

    int total = 0;
    int bad   = 0;
    int ld_cnt = 0;

    always #5 clk = ~clk;

    piso_serializer_64 u_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(m_in_ready), .ser_out(m_ser_out), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_last(m_out_last), .busy(m_busy)
    );

    piso_serializer_64 #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(l_in_ready), .ser_out(l_ser_out), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_last(l_out_last), .busy(l_busy)
    );

    piso_serializer_64 #(.LANE_W(64)) u_w64 (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(w_in_ready), .ser_out(w_ser_out), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_last(w_out_last), .busy(w_busy)
    );

    // Inputs settle 1 ns after posedge, so negedge sees exactly what the next edge will.
    always @(negedge clk) if (rst && in_valid && m_in_ready) ld_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic load_word(input logic [63:0] w);
        data_in  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    logic [7:0] msb1 [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    logic [7:0] lsb1 [8] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    logic [7:0] ff00 [8] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
    logic [63:0] wseq [4] = '{64'hDEAD_BEEF_0000_0001, 64'h1234_5678_9ABC_DEF0,
                              64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};

    initial begin
        int b;
        int stall;
        int guard;

        // Reset state
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
        step();
        chk("rst_out_valid", m_out_valid, 1'b0);
        chk("rst_in_ready",  m_in_ready, 1'b0);
        chk("rst_busy",      m_busy, 1'b0);
        chk("rst_ser_out",   m_ser_out, 8'h00);
        chk("rst_out_last",  m_out_last, 1'b0);
        chk("rst_w_in_ready", w_in_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("idle_in_ready", m_in_ready, 1'b1);

        // 1 & 2: MSB-first and LSB-first ordering of the same word
        load_word(64'h0123_4567_89AB_CDEF);
        chk("w64_beat", w_ser_out, 64'h0123_4567_89AB_CDEF);
        chk("w64_last", w_out_last, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_valid%0d", i), m_out_valid, 1'b1);
            chk($sformatf("t1_beat%0d", i), m_ser_out, msb1[i]);
            chk($sformatf("t1_last%0d", i), m_out_last, (i == 7));
            chk($sformatf("t2_beat%0d", i), l_ser_out, lsb1[i]);
            chk($sformatf("t2_last%0d", i), l_out_last, (i == 7));
            step();
        end
        chk("t1_end_valid", m_out_valid, 1'b0);
        chk("t1_end_ready", m_in_ready, 1'b1);
        chk("t1_end_busy",  m_busy, 1'b0);
        chk("t2_end_valid", l_out_valid, 1'b0);

        // 3: back-to-back words, zero bubble
        do_reset();
        ld_cnt   = 0;
        data_in  = 64'h1111_1111_1111_1111;
        in_valid = 1'b1;
        step();
        data_in  = 64'h2222_2222_2222_2222;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) in_valid = 1'b0;
            chk($sformatf("t3_valid%0d", k), m_out_valid, 1'b1);
            chk($sformatf("t3_beat%0d", k), m_ser_out, (k < 8) ? 8'h11 : 8'h22);
            chk($sformatf("t3_last%0d", k), m_out_last, (k == 7 || k == 15));
            step();
        end
        chk("t3_end_valid", m_out_valid, 1'b0);
        chk("t3_loads", ld_cnt, 2);

        // 4: backpressure on the third beat, in_valid asserted but ignored
        do_reset();
        load_word(64'h0123_4567_89AB_CDEF);
        b = 0; stall = 0; guard = 0;
        while (b < 8 && guard < 40) begin
            guard++;
            chk($sformatf("t4_valid%0d", b), m_out_valid, 1'b1);
            chk($sformatf("t4_beat%0d", b), m_ser_out, msb1[b]);
            chk($sformatf("t4_last%0d", b), m_out_last, (b == 7));
            if (b == 2 && stall < 3) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                data_in   = 64'hDEAD_DEAD_DEAD_DEAD;
                #1;
                chk($sformatf("t4_stall_ready%0d", stall), m_in_ready, 1'b0);
                stall++;
            end else begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
                b++;
            end
            step();
        end
        chk("t4_beats", b, 8);
        chk("t4_stalls", stall, 3);
        chk("t4_end_valid", m_out_valid, 1'b0);

        // 5: asynchronous reset mid-word, then a clean new word
        do_reset();
        load_word(64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 4; i++) step();
        chk("t5_pre_beat", m_ser_out, 8'h89);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_async_valid", m_out_valid, 1'b0);
        chk("t5_async_ser",   m_ser_out, 8'h00);
        chk("t5_async_busy",  m_busy, 1'b0);
        #6;
        rst = 1'b1;
        step();
        chk("t5_post_ready", m_in_ready, 1'b1);
        chk("t5_post_valid", m_out_valid, 1'b0);
        load_word(64'hFFFF_0000_FFFF_0000);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_beat%0d", i), m_ser_out, ff00[i]);
            step();
        end

        // 6: full-width lane, one word per cycle
        do_reset();
        data_in  = wseq[0];
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t6_valid%0d", i), w_out_valid, 1'b1);
            chk($sformatf("t6_beat%0d", i), w_ser_out, wseq[i]);
            chk($sformatf("t6_last%0d", i), w_out_last, 1'b1);
            chk($sformatf("t6_ready%0d", i), w_in_ready, 1'b1);
            if (i < 3) data_in = wseq[i+1];
            else       in_valid = 1'b0;
        end
        step();
        chk("t6_end_valid", w_out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
